nioshello_mem_tester: RTL

Avalon-MM master that drives the on-chip RAM's slave port: it fills a region with a deterministic pattern, reads it back and counts mismatches. It sits beside the Nios II data master on the same on-chip memory slave. The system uses it for power-on memory self-test and for bring-up checks of the RAM macro. The slave it targets has no waitrequest and a fixed read latency of one clock.

---
 rtl/nioshello_mem_tester.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/nioshello_mem_tester.sv
// nioshello_mem_tester: Avalon-MM self-test master that writes seed+i over a RAM
// region, reads it back through a latency-matched compare pipeline and counts mismatches.
module nioshello_mem_tester #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic                m_clken,
    input  logic [DATA_W-1:0]   m_readdata
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
    localparam logic [2:0]    LAST    = 3'(READ_LATENCY - 1);
    localparam logic [ADDR_W:0] CNT_MAX = '1;
    state_t              state_q;
    logic [ADDR_W:0]     idx_q, n_q, cnt_q;
    logic [ADDR_W-1:0]   base_q, addr_q, ferr_q;
    logic [DATA_W-1:0]   seed_q, pat_q, wdata_q;
    logic                cs_q, wr_q, busy_q, done_q, err_q, clken_q;
    logic [2:0]          drain_q;
    logic                pv_q [READ_LATENCY];
    logic [DATA_W-1:0]   pd_q [READ_LATENCY];
    logic [ADDR_W-1:0]   pa_q [READ_LATENCY];
    logic                last_i, mis;
    assign last_i = idx_q == n_q - 1'b1;
    // The oldest pipeline stage lines up with the slave's readdata for that read
    assign mis = pv_q[READ_LATENCY-1] && (m_readdata != pd_q[READ_LATENCY-1]);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            ferr_q  <= '0;
            seed_q  <= '0;
            pat_q   <= '0;
            wdata_q <= '0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            clken_q <= 1'b0;
            drain_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pv_q[k] <= 1'b0;
                pd_q[k] <= '0;
                pa_q[k] <= '0;
            end
        end else begin
            clken_q <= 1'b1;
            done_q  <= 1'b0;
            pv_q[0] <= state_q == READ;
            pd_q[0] <= pat_q;
            pa_q[0] <= addr_q;
            for (int k = 1; k < READ_LATENCY; k++) begin
                pv_q[k] <= pv_q[k-1];
                pd_q[k] <= pd_q[k-1];
                pa_q[k] <= pa_q[k-1];
            end
            if (mis) begin
                err_q <= 1'b1;
                if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
                if (cnt_q == '0) ferr_q <= pa_q[READ_LATENCY-1];
            end
            case (state_q)
                IDLE: if (start) begin
                    err_q  <= 1'b0;
                    cnt_q  <= '0;
                    ferr_q <= '0;
                    base_q <= base_addr;
                    n_q    <= word_count;
                    seed_q <= seed;
                    idx_q  <= '0;
                    if (word_count == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= WRITE;
                        busy_q  <= 1'b1;
                        cs_q    <= 1'b1;
                        wr_q    <= 1'b1;
                        addr_q  <= base_addr;
                        pat_q   <= seed;
                        wdata_q <= seed;
                    end
                end
                WRITE: begin
                    idx_q   <= last_i ? '0 : idx_q + 1'b1;
                    addr_q  <= last_i ? base_q : addr_q + 1'b1;
                    pat_q   <= last_i ? seed_q : pat_q + 1'b1;
                    wdata_q <= last_i ? '0 : pat_q + 1'b1;
                    if (last_i) begin
                        wr_q    <= 1'b0;
                        state_q <= READ;
                    end
                end
                READ: begin
                    idx_q  <= idx_q + 1'b1;
                    addr_q <= addr_q + 1'b1;
                    pat_q  <= pat_q + 1'b1;
                    if (last_i) begin
                        state_q <= DRAIN;
                        cs_q    <= 1'b0;
                        addr_q  <= '0;
                        drain_q <= '0;
                    end
                end
                DRAIN: begin
                    drain_q <= drain_q + 1'b1;
                    if (drain_q == LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = err_q;
    assign err_count      = cnt_q;
    assign first_err_addr = ferr_q;
    assign m_address      = addr_q;
    assign m_byteenable   = '1;
    assign m_chipselect   = cs_q;
    assign m_write        = wr_q;
    assign m_writedata    = wdata_q;
    assign m_clken        = clken_q;
endmodule
